chain_encoder: RTL and testbench
================================

// Module: chain_encoder
// PURPOSE
//  Freeman 8-direction chain-code encoder; the inverse of the boundary decoder.
//  Accepts an ordered stream of boundary pixels for one object. Emits one 8-bit
//  code per step plus start pixel, perimeter (code count) and area, in the form
//  the decoder consumes. Sits between the boundary tracer and code memory.
// PARAMETERS
//  MAX_CODES  255  code-count limit; exceeding it raises error (fits 8-bit perimeter)
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  start          in   1   1-cycle pulse; arms encoder for a new object
//  pix_valid      in   1   pixel handshake valid
//  pix_ready      out  1   pixel handshake ready
//  pix_x          in   7   pixel column
//  pix_y          in   7   pixel row (y grows downward)
//  pix_last       in   1   marks final boundary pixel of object
//  code_valid     out  1   code handshake valid
//  code_ready     in   1   code handshake ready
//  code           out  8   chain code 0..7, zero-extended
//  start_pixel_x  out  7   first accepted pixel column
//  start_pixel_y  out  7   first accepted pixel row
//  perimeter      out  8   number of codes emitted
//  area           out  12  shoelace polygon area (needs CHAIN_AREA_EN)
//  done           out  1   sticky, object encoded cleanly
//  error          out  1   sticky, illegal step or overflow
// BEHAVIOUR
//  Reset: all outputs 0, state S_IDLE; reset mid-object aborts with no partial code.
//  Direction map (dx,dy -> code): (+1,0)=0 (+1,-1)=1 (0,-1)=2 (-1,-1)=3 (-1,0)=4
//    (-1,+1)=5 (0,+1)=6 (+1,+1)=7. dx/dy are signed 8-bit differences; no
//    wrap-around, so 127->0 is illegal. Any other (dx,dy), incl. (0,0), is illegal.
//  FSM:
//    S_IDLE: start -> S_FIRST; clear perimeter/area/done/error.
//    S_FIRST: pix_ready=1. On accept, latch start_pixel_x/y and prev.
//      pix_last=1 -> S_DONE with perimeter 0. Else -> S_STEP.
//    S_STEP: pix_ready = !code_valid | code_ready. On accept, load code register
//      from map(pix - prev), perimeter+1, prev<=pix. Throughput 1 pixel/cycle.
//      Code output valid 1 cycle after pixel accept.
//      Illegal step -> S_ERROR, no code emitted.
//      perimeter would exceed MAX_CODES -> S_ERROR.
//      pix_last accepted -> S_CLOSE.
//    S_CLOSE: pix_ready=0. When the code register frees, emit closing code
//      map(start - prev). Illegal -> S_ERROR. If prev==start, emit nothing.
//      -> S_DRAIN.
//    S_DRAIN: wait !code_valid -> S_DONE.
//    S_DONE: done=1 -> S_IDLE. S_ERROR: error=1, code_valid dropped -> S_IDLE.
//  code_valid held with code stable until code_ready (no drop, no change).
//  done/error sticky until next start. start outside S_IDLE is ignored.
//  Simultaneous pix accept and code accept in the same cycle are both legal.
// CONFIGURATION
//  CHAIN_AREA_EN defined: per code, signed 16-bit acc += x_prev*y_new - x_new*y_prev
//    (same step as perimeter++). At S_DONE, area = |acc|>>1, saturated to 4095.
//  Undefined: no multiplier or accumulator; area tied to 0.
// STRUCTURE
//  Package border_flow_pkg holds:
//    - code constants CC_E..CC_SE (0..7)
//    - FSM state typedef
//    - COORD_W=7, PERIM_W=8, AREA_W=12
//  Sub-module chain_dir_lut: combinational (dx,dy) -> {legal, code[2:0]}.
//    Shared by S_STEP and S_CLOSE.
// TESTING
//  1. 2x2 square (10,10)(11,10)(11,11)(10,11, last)
//     -> codes 0,6,4,2; perimeter=4; start=(10,10);
//        area=1 if CHAIN_AREA_EN; done=1.
//  2. Single pixel (5,5) with last in S_FIRST
//     -> no codes; perimeter=0; done=1; error=0.
//  3. Jump (20,20)->(22,20)
//     -> no code for jump; error=1; done=0; idle.
//     Also: (127,0)->(0,0) gives error.
//  4. code_ready low 5 cycles mid-stream
//     -> code held stable; pix_ready=0 while full; no loss or dup.
//  5. reset low mid-object after 3 codes
//     -> all outputs 0; next start encodes fresh object correctly.
//  6. 256-step stream with MAX_CODES=255
//     -> error at 256th code; perimeter stays 255.

Source files
------------

// File: rtl/border_flow_pkg.sv
// Shared types and constants for the chain-code encoder slice.
// Direction codes follow the Freeman order: E=0 counter-clockwise to SE=7 (y grows downward).
package border_flow_pkg;

    localparam int COORD_W = 7;
    localparam int PERIM_W = 8;
    localparam int AREA_W  = 12;

    localparam logic [2:0] CC_E  = 3'd0;
    localparam logic [2:0] CC_NE = 3'd1;
    localparam logic [2:0] CC_N  = 3'd2;
    localparam logic [2:0] CC_NW = 3'd3;
    localparam logic [2:0] CC_W  = 3'd4;
    localparam logic [2:0] CC_SW = 3'd5;
    localparam logic [2:0] CC_S  = 3'd6;
    localparam logic [2:0] CC_SE = 3'd7;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_FIRST = 3'd1;
    localparam state_t S_STEP  = 3'd2;
    localparam state_t S_CLOSE = 3'd3;
    localparam state_t S_DRAIN = 3'd4;
    localparam state_t S_DONE  = 3'd5;
    localparam state_t S_ERROR = 3'd6;

endpackage

// File: rtl/chain_dir_lut.sv
// Maps a signed 8-bit step (dx,dy) to a Freeman code; only unit 8-neighbour steps are legal.
// Latency: combinational.
// Backpressure: none.
module chain_dir_lut
    import border_flow_pkg::*;
(
    input  logic [7:0] i_dx,
    input  logic [7:0] i_dy,
    output logic       o_legal,
    output logic [2:0] o_code
);

    localparam logic [7:0] P1 = 8'h01;
    localparam logic [7:0] Z0 = 8'h00;
    localparam logic [7:0] M1 = 8'hFF;

    always_comb begin
        o_legal = 1'b1;
        o_code  = CC_E;
        case ({i_dx, i_dy})
            {P1, Z0}: o_code = CC_E;
            {P1, M1}: o_code = CC_NE;
            {Z0, M1}: o_code = CC_N;
            {M1, M1}: o_code = CC_NW;
            {M1, Z0}: o_code = CC_W;
            {M1, P1}: o_code = CC_SW;
            {Z0, P1}: o_code = CC_S;
            {P1, P1}: o_code = CC_SE;
            default:  o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/chain_encoder.sv
// Freeman chain-code encoder: boundary pixels in, one code per step plus closing code; area via CHAIN_AREA_EN.
// Latency: code valid one cycle after pixel accept; closing code as soon as the code register frees.
// Backpressure: single code register; pix_ready is low while it is full and code_ready is low.
module chain_encoder
    import border_flow_pkg::*;
#(
    parameter int MAX_CODES = 255
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               pix_last,
    output logic               code_valid,
    input  logic               code_ready,
    output logic [7:0]         code,
    output logic [COORD_W-1:0] start_pixel_x,
    output logic [COORD_W-1:0] start_pixel_y,
    output logic [PERIM_W-1:0] perimeter,
    output logic [AREA_W-1:0]  area,
    output logic               done,
    output logic               error
);

    state_t             r_state;
    logic               r_code_vld;
    logic [2:0]         r_code;
    logic [COORD_W-1:0] r_spx, r_spy;
    logic [COORD_W-1:0] r_px, r_py;
    logic [PERIM_W-1:0] r_perim;
    logic               r_done, r_err;

    logic [COORD_W-1:0] w_new_x, w_new_y;
    logic [7:0]         w_dx, w_dy;
    logic               w_legal;
    logic [2:0]         w_lut_code;
    logic               w_pix_acc, w_reg_free, w_at_max, w_same;
    logic               w_load, w_fault;

    // The closing step reuses the same LUT, targeting the start pixel instead of the input.
    assign w_new_x = (r_state == S_CLOSE) ? r_spx : pix_x;
    assign w_new_y = (r_state == S_CLOSE) ? r_spy : pix_y;
    assign w_dx    = {1'b0, w_new_x} - {1'b0, r_px};
    assign w_dy    = {1'b0, w_new_y} - {1'b0, r_py};

    chain_dir_lut u_lut (
        .i_dx    (w_dx),
        .i_dy    (w_dy),
        .o_legal (w_legal),
        .o_code  (w_lut_code)
    );

    assign w_reg_free = !r_code_vld || code_ready;
    assign w_at_max   = ({1'b0, r_perim} >= (PERIM_W+1)'(MAX_CODES));
    assign w_same     = (r_px == r_spx) && (r_py == r_spy);

    always_comb begin
        pix_ready = 1'b0;
        case (r_state)
            S_FIRST: pix_ready = 1'b1;
            S_STEP:  pix_ready = w_reg_free;
            default: pix_ready = 1'b0;
        endcase
    end

    assign w_pix_acc = pix_valid && pix_ready;

    always_comb begin
        w_load  = 1'b0;
        w_fault = 1'b0;
        if (r_state == S_STEP && w_pix_acc) begin
            w_fault = !w_legal || w_at_max;
            w_load  = !w_fault;
        end else if (r_state == S_CLOSE && w_reg_free && !w_same) begin
            w_fault = !w_legal || w_at_max;
            w_load  = !w_fault;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_code_vld <= 1'b0;
            r_code     <= 3'd0;
            r_spx      <= '0;
            r_spy      <= '0;
            r_px       <= '0;
            r_py       <= '0;
            r_perim    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (r_code_vld && code_ready)
                r_code_vld <= 1'b0;
            if (w_load) begin
                r_code     <= w_lut_code;
                r_code_vld <= 1'b1;
                r_perim    <= r_perim + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FIRST;
                        r_perim <= '0;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                S_FIRST: begin
                    if (w_pix_acc) begin
                        r_spx   <= pix_x;
                        r_spy   <= pix_y;
                        r_px    <= pix_x;
                        r_py    <= pix_y;
                        r_state <= pix_last ? S_DONE : S_STEP;
                    end
                end
                S_STEP: begin
                    if (w_fault) begin
                        r_state <= S_ERROR;
                    end else if (w_load) begin
                        r_px <= pix_x;
                        r_py <= pix_y;
                        if (pix_last)
                            r_state <= S_CLOSE;
                    end
                end
                S_CLOSE: begin
                    if (w_fault)
                        r_state <= S_ERROR;
                    else if (w_reg_free)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!r_code_vld)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_ERROR: begin
                    r_err      <= 1'b1;
                    r_code_vld <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CHAIN_AREA_EN
    logic [15:0]       r_acc;
    logic [AREA_W-1:0] r_area;
    logic [15:0]       w_term, w_abs, w_half;
    logic [AREA_W-1:0] w_area_sat;

    // Shoelace term; 16-bit wrap gives the two's-complement signed difference.
    always_comb begin
        w_term     = ({9'd0, r_px} * {9'd0, w_new_y}) - ({9'd0, w_new_x} * {9'd0, r_py});
        w_abs      = r_acc[15] ? (16'd0 - r_acc) : r_acc;
        w_half     = {1'b0, w_abs[15:1]};
        w_area_sat = (w_half > 16'd4095) ? {AREA_W{1'b1}} : w_half[AREA_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc  <= '0;
            r_area <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_acc  <= '0;
            r_area <= '0;
        end else if (w_load) begin
            r_acc <= r_acc + w_term;
        end else if (r_state == S_DONE) begin
            r_area <= w_area_sat;
        end
    end

    assign area = r_area;
`else
    assign area = '0;
`endif

    assign code_valid    = r_code_vld;
    assign code          = {5'd0, r_code};
    assign start_pixel_x = r_spx;
    assign start_pixel_y = r_spy;
    assign perimeter     = r_perim;
    assign done          = r_done;
    assign error         = r_err;

endmodule

// File: tb/tb_chain_encoder.sv
// Directed bench for chain_encoder: table of whole objects plus stall, reset and overflow sequences.
`timescale 1ns/1ps
module tb_chain_encoder;

`ifdef CHAIN_AREA_EN
    localparam bit AREA_ON = 1'b1;
`else
    localparam bit AREA_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, pix_valid, pix_last, code_ready;
    logic [6:0] pix_x, pix_y;
    logic       pix_ready, code_valid, done, error;
    logic [7:0] code, perimeter;
    logic [6:0] start_pixel_x, start_pixel_y;
    logic [11:0] area;

    always #5 clk = ~clk;

    chain_encoder #(.MAX_CODES(255)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_last      (pix_last),
        .code_valid    (code_valid),
        .code_ready    (code_ready),
        .code          (code),
        .start_pixel_x (start_pixel_x),
        .start_pixel_y (start_pixel_y),
        .perimeter     (perimeter),
        .area          (area),
        .done          (done),
        .error         (error)
    );

    typedef int arr8_t [8];
    typedef struct {
        int    npix;
        arr8_t xs;
        arr8_t ys;
        int    ncodes;
        arr8_t codes;
        int    perim;
        int    area;
        int    done;
        int    err;
    } vec_t;

    localparam int NVEC = 7;
    vec_t tv [NVEC];

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] got [$];

    always @(negedge clk)
        if (reset && code_valid && code_ready)
            got.push_back(code);

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input int np, input arr8_t xs, input arr8_t ys,
                           input int nc, input arr8_t cs, input int pe, input int ar,
                           input int dn, input int er);
        tv[i].npix = np; tv[i].xs = xs; tv[i].ys = ys; tv[i].ncodes = nc;
        tv[i].codes = cs; tv[i].perim = pe; tv[i].area = ar; tv[i].done = dn; tv[i].err = er;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_pix(input int x, input int y, input bit last);
        bit ok;
        ok = 1'b0;
        pix_valid = 1'b1; pix_x = x[6:0]; pix_y = y[6:0]; pix_last = last;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (pix_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        pix_valid = 1'b0; pix_last = 1'b0;
        if (!ok) chk("pix_accept", int'(ok), 1);
    endtask

    task automatic wait_end();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (done || error) seen = 1'b1;
        end
        if (!seen) chk("end_wait", int'(done | error), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i);
        got.delete();
        pulse_start();
        for (int p = 0; p < tv[i].npix; p++)
            send_pix(tv[i].xs[p], tv[i].ys[p], p == tv[i].npix - 1);
        wait_end();
        chk($sformatf("v%0d ncodes", i), got.size(), tv[i].ncodes);
        for (int c = 0; c < tv[i].ncodes && c < got.size(); c++)
            chk($sformatf("v%0d code%0d", i, c), int'(got[c]), tv[i].codes[c]);
        chk($sformatf("v%0d perimeter", i), int'(perimeter), tv[i].perim);
        chk($sformatf("v%0d area", i), int'(area), AREA_ON ? tv[i].area : 0);
        chk($sformatf("v%0d done", i), int'(done), tv[i].done);
        chk($sformatf("v%0d error", i), int'(error), tv[i].err);
        chk($sformatf("v%0d start_x", i), int'(start_pixel_x), tv[i].xs[0]);
        chk($sformatf("v%0d start_y", i), int'(start_pixel_y), tv[i].ys[0]);
        chk($sformatf("v%0d code_valid", i), int'(code_valid), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " pix_ready"}, int'(pix_ready), 0);
        chk({tag, " code_valid"}, int'(code_valid), 0);
        chk({tag, " code"}, int'(code), 0);
        chk({tag, " start_x"}, int'(start_pixel_x), 0);
        chk({tag, " start_y"}, int'(start_pixel_y), 0);
        chk({tag, " perimeter"}, int'(perimeter), 0);
        chk({tag, " area"}, int'(area), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " error"}, int'(error), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_vec(0, 4, '{10,11,11,10,0,0,0,0}, '{10,10,11,11,0,0,0,0},
                4, '{0,6,4,2,0,0,0,0}, 4, 1, 1, 0);
        set_vec(1, 1, '{5,0,0,0,0,0,0,0}, '{5,0,0,0,0,0,0,0},
                0, '{0,0,0,0,0,0,0,0}, 0, 0, 1, 0);
        set_vec(2, 2, '{20,22,0,0,0,0,0,0}, '{20,20,0,0,0,0,0,0},
                0, '{0,0,0,0,0,0,0,0}, 0, 0, 0, 1);
        set_vec(3, 2, '{127,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0},
                0, '{0,0,0,0,0,0,0,0}, 0, 0, 0, 1);
        set_vec(4, 3, '{0,1,2,0,0,0,0,0}, '{0,1,0,0,0,0,0,0},
                2, '{7,1,0,0,0,0,0,0}, 2, 0, 0, 1);
        set_vec(5, 3, '{3,4,3,0,0,0,0,0}, '{3,3,3,0,0,0,0,0},
                2, '{0,4,0,0,0,0,0,0}, 2, 0, 1, 0);
        set_vec(6, 8, '{10,11,12,12,11,10,9,9}, '{10,10,9,8,7,7,8,9},
                8, '{0,1,2,3,4,5,6,7}, 8, 7, 1, 0);

        reset = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_last = 1'b0;
        pix_x = '0; pix_y = '0; code_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++)
            run_vec(i);

        // Stall: code held while consumer is not ready, and no new pixel taken.
        got.delete();
        code_ready = 1'b0;
        pulse_start();
        send_pix(10, 10, 1'b0);
        send_pix(11, 10, 1'b0);
        pix_valid = 1'b1; pix_x = 7'd11; pix_y = 7'd11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall code_valid", int'(code_valid), 1);
            chk("stall code", int'(code), 0);
            chk("stall pix_ready", int'(pix_ready), 0);
        end
        @(posedge clk); #1;
        chk("stall no_pop", got.size(), 0);
        pix_valid = 1'b0;
        code_ready = 1'b1;
        send_pix(11, 11, 1'b0);
        send_pix(10, 11, 1'b1);
        wait_end();
        chk("stall ncodes", got.size(), 4);
        if (got.size() == 4) begin
            chk("stall c0", int'(got[0]), 0);
            chk("stall c1", int'(got[1]), 6);
            chk("stall c2", int'(got[2]), 4);
            chk("stall c3", int'(got[3]), 2);
        end
        chk("stall perimeter", int'(perimeter), 4);
        chk("stall done", int'(done), 1);

        // Reset in the middle of an object, then a fresh object.
        got.delete();
        pulse_start();
        send_pix(10, 10, 1'b0);
        send_pix(11, 10, 1'b0);
        send_pix(11, 11, 1'b0);
        send_pix(10, 11, 1'b0);
        chk("pre-reset perimeter", int'(perimeter), 3);
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_vec(0);

        // Overflow: 255 codes fit, the 256th step errors.
        got.delete();
        pulse_start();
        send_pix(10, 10, 1'b0);
        for (int i = 1; i <= 255; i++)
            send_pix((i % 2 == 1) ? 11 : 10, 10, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf perimeter255", int'(perimeter), 255);
        chk("ovf no_error_yet", int'(error), 0);
        chk("ovf ncodes255", got.size(), 255);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("ovf code%0d", i), int'(got[i]), (i % 2 == 0) ? 0 : 4);
        send_pix(10, 10, 1'b0);
        wait_end();
        chk("ovf error", int'(error), 1);
        chk("ovf done", int'(done), 0);
        chk("ovf perimeter", int'(perimeter), 255);
        chk("ovf ncodes", got.size(), 255);
        chk("ovf pix_ready", int'(pix_ready), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
